// File: rtl/uart_fifo_mmio.sv
// uart_fifo_mmio: memory-mapped 8N1 UART with TX/RX FIFOs, runtime baud divisor,
// sticky error flags (tx_ovf, rx_ovf, frame_err) and a registered level interrupt.
module uart_fifo_mmio #(
    parameter int CLK_HZ   = 12000000,
    parameter int BAUD     = 115200,
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk12MHz,
    input  logic        rst,
    input  logic        valid,
    input  logic [1:0]  reg_sel,
    input  logic        read,
    input  logic [3:0]  wmask,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        irq,
    input  logic        rxd,
    output logic        txd
);
    localparam logic [15:0] DIV0 = 16'(CLK_HZ / BAUD);
    localparam int TXAW = $clog2(TX_DEPTH);
    localparam int RXAW = $clog2(RX_DEPTH);
    localparam logic [TXAW:0] TX_FULL_CNT = (TXAW+1)'(TX_DEPTH);
    localparam logic [RXAW:0] RX_FULL_CNT = (RXAW+1)'(RX_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

    // A write wins over a simultaneous read strobe.
    logic wr, rd, w1c;
    assign wr  = valid & (|wmask);
    assign rd  = valid & read & ~wr;
    assign w1c = wr & (reg_sel == 2'd1) & wmask[0];

    logic [15:0] div_reg, div_new;
    logic [1:0]  ctrl;
    logic        tx_ovf, rx_ovf, frame_err;
    logic [31:0] status;
    logic        unused_hi;
    assign unused_hi = ^data_in[31:16];

    // ---------------- TX FIFO ----------------
    logic [7:0]      tx_mem [TX_DEPTH];
    logic [TXAW-1:0] tx_wptr, tx_rptr;
    logic [TXAW:0]   tx_count;
    logic            tx_empty, tx_full, tx_push_req, tx_push, tx_pop, tx_idle;

    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_div;
    logic [2:0]  tx_bitidx;
    logic [7:0]  tx_shift;
    logic        tx_bit_end;

    assign tx_empty    = (tx_count == '0);
    assign tx_full     = (tx_count == TX_FULL_CNT);
    assign tx_push_req = wr & (reg_sel == 2'd0) & wmask[0];
    assign tx_pop      = (tx_state == TX_IDLE) & ~tx_empty;
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    assign tx_idle     = tx_empty & (tx_state == TX_IDLE);

    // TX FIFO storage
    always_ff @(posedge clk12MHz) begin
        if (tx_push) tx_mem[tx_wptr] <= data_in[7:0];
    end

    // TX FIFO pointers and occupancy
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + TXAW'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + TXAW'(1);
            tx_count <= tx_count + (TXAW+1)'(tx_push) - (TXAW+1)'(tx_pop);
        end
    end

    // ---------------- TX shifter ----------------
    assign tx_bit_end = (tx_cnt == tx_div - 16'd1);

    // TX next-state logic
    always_comb begin
        tx_state_n = tx_state;
        case (tx_state)
            TX_IDLE:  if (!tx_empty) tx_state_n = TX_START;
            TX_START: if (tx_bit_end) tx_state_n = TX_DATA;
            TX_DATA:  if (tx_bit_end && tx_bitidx == 3'd7) tx_state_n = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_state_n = TX_IDLE;
            default:  tx_state_n = TX_IDLE;
        endcase
    end

    // TX state register
    always_ff @(posedge clk12MHz) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_state_n;
    end

    // TX bit-period counter and bit index
    always_ff @(posedge clk12MHz) begin
        if (rst || tx_state == TX_IDLE) begin
            tx_cnt    <= '0;
            tx_bitidx <= '0;
        end else if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_state == TX_DATA) tx_bitidx <= tx_bitidx + 3'd1;
        end else begin
            tx_cnt <= tx_cnt + 16'd1;
        end
    end

    // Byte and divisor captured at pop so a divisor change never disturbs a frame in flight
    always_ff @(posedge clk12MHz) begin
        if (tx_pop) begin
            tx_shift <= tx_mem[tx_rptr];
            tx_div   <= div_reg;
        end else if (tx_state == TX_DATA && tx_bit_end) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
        end
    end

    assign txd = (tx_state == TX_START) ? 1'b0 :
                 (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

    // ---------------- RX path ----------------
    logic            rx_s1, rx_s2, rx_s3;
    logic            rx_fall, rx_mid, rx_bit_end, rx_done, rx_ferr;
    rx_state_t       rx_state, rx_state_n;
    logic [15:0]     rx_cnt, rx_div;
    logic [2:0]      rx_bitidx;
    logic [7:0]      rx_shift;
    logic [7:0]      rx_mem [RX_DEPTH];
    logic [RXAW-1:0] rx_wptr, rx_rptr;
    logic [RXAW:0]   rx_count;
    logic            rx_empty, rx_full, rx_push, rx_pop;

    // Two-flop synchroniser plus one delay stage for edge detection
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    assign rx_fall    = rx_s3 & ~rx_s2;
    assign rx_mid     = (rx_cnt == {1'b0, rx_div[15:1]});
    assign rx_bit_end = (rx_cnt == rx_div - 16'd1);
    assign rx_done    = (rx_state == RX_STOP) & rx_bit_end & rx_s2;
    assign rx_ferr    = (rx_state == RX_STOP) & rx_bit_end & ~rx_s2;

    // RX next-state logic; a bad stop bit waits for the line to go high again
    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_state_n = RX_START;
            RX_START: if (rx_mid) rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_end && rx_bitidx == 3'd7) rx_state_n = RX_STOP;
            RX_STOP:  if (rx_bit_end) rx_state_n = rx_s2 ? RX_IDLE : RX_BREAK;
            RX_BREAK: if (rx_s2) rx_state_n = RX_IDLE;
            default:  rx_state_n = RX_IDLE;
        endcase
    end

    // RX state register
    always_ff @(posedge clk12MHz) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_state_n;
    end

    // RX sample counter: restarts at the mid-start sample, then one full period per bit
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            rx_cnt    <= '0;
            rx_bitidx <= '0;
        end else begin
            case (rx_state)
                RX_START: rx_cnt <= rx_mid ? 16'd0 : rx_cnt + 16'd1;
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt    <= '0;
                        rx_bitidx <= rx_bitidx + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_STOP: rx_cnt <= rx_cnt + 16'd1;
                default: begin
                    rx_cnt    <= '0;
                    rx_bitidx <= '0;
                end
            endcase
        end
    end

    // RX divisor latch while idle and LSB-first data shift
    always_ff @(posedge clk12MHz) begin
        if (rx_state == RX_IDLE) rx_div <= div_reg;
        if (rx_state == RX_DATA && rx_bit_end) rx_shift <= {rx_s2, rx_shift[7:1]};
    end

    assign rx_empty = (rx_count == '0);
    assign rx_full  = (rx_count == RX_FULL_CNT);
    assign rx_pop   = rd & (reg_sel == 2'd0) & ~rx_empty;
    assign rx_push  = rx_done & (~rx_full | rx_pop);

    // RX FIFO storage
    always_ff @(posedge clk12MHz) begin
        if (rx_push) rx_mem[rx_wptr] <= rx_shift;
    end

    // RX FIFO pointers and occupancy
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + RXAW'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + RXAW'(1);
            rx_count <= rx_count + (RXAW+1)'(rx_push) - (RXAW+1)'(rx_pop);
        end
    end

    // ---------------- Registers ----------------
    assign status = {8'd0, 8'(tx_count), 8'(rx_count), frame_err, tx_idle,
                     rx_ovf, tx_ovf, rx_full, rx_empty, tx_full, tx_empty};

    // Byte-lane merge of a DIV write
    always_comb begin
        div_new = div_reg;
        if (wmask[0]) div_new[7:0]  = data_in[7:0];
        if (wmask[1]) div_new[15:8] = data_in[15:8];
    end

    // DIV and CTRL registers; divisors below 4 are clamped
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            div_reg <= DIV0;
            ctrl    <= '0;
        end else if (wr) begin
            if (reg_sel == 2'd2) div_reg <= (div_new < 16'd4) ? 16'd4 : div_new;
            if (reg_sel == 2'd3 && wmask[0]) ctrl <= data_in[1:0];
        end
    end

    // Sticky flags: write-one-to-clear, a new event in the same cycle wins
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            tx_ovf    <= 1'b0;
            rx_ovf    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (w1c && data_in[4]) tx_ovf    <= 1'b0;
            if (w1c && data_in[5]) rx_ovf    <= 1'b0;
            if (w1c && data_in[7]) frame_err <= 1'b0;
            if (tx_push_req && !tx_push)     tx_ovf    <= 1'b1;
            if (rx_done && rx_full && !rx_pop) rx_ovf  <= 1'b1;
            if (rx_ferr)                     frame_err <= 1'b1;
        end
    end

    // Registered read data, held between reads
    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            data_out <= '0;
        end else if (rd) begin
            case (reg_sel)
                2'd0:    data_out <= rx_empty ? 32'd0 : {23'd0, 1'b1, rx_mem[rx_rptr]};
                2'd1:    data_out <= status;
                2'd2:    data_out <= {16'd0, div_reg};
                default: data_out <= {30'd0, ctrl};
            endcase
        end
    end

    // Registered level interrupt
    always_ff @(posedge clk12MHz) begin
        if (rst) irq <= 1'b0;
        else     irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty);
    end
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// tb_uart_fifo_mmio: scoreboard-driven bench for uart_fifo_mmio at the reset divisor (104).
module tb_uart_fifo_mmio;
    logic        clk12MHz = 1'b0;
    logic        rst, valid, read, rxd;
    logic [1:0]  reg_sel;
    logic [3:0]  wmask;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        irq, txd;

    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    logic [7:0]  tx_q[$];
    logic [31:0] rx_q[$];

    uart_fifo_mmio dut (
        .clk12MHz(clk12MHz), .rst(rst), .valid(valid), .reg_sel(reg_sel),
        .read(read), .wmask(wmask), .data_in(data_in), .data_out(data_out),
        .irq(irq), .rxd(rxd), .txd(txd)
    );

    always #5 clk12MHz = ~clk12MHz;
    always @(posedge clk12MHz) cyc <= cyc + 1;

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk12MHz);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] sel, input logic [3:0] m, input logic [31:0] d);
        valid = 1'b1; read = 1'b0; reg_sel = sel; wmask = m; data_in = d;
        @(posedge clk12MHz); #1;
        valid = 1'b0; wmask = 4'd0;
    endtask

    task automatic bus_read(input logic [1:0] sel, output logic [31:0] d);
        valid = 1'b1; read = 1'b1; wmask = 4'd0; reg_sel = sel;
        @(posedge clk12MHz); #1;
        valid = 1'b0; read = 1'b0;
        d = data_out;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        wait_cycles(104);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cycles(104);
        end
        rxd = stop;
        wait_cycles(104);
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1; valid = 1'b0; read = 1'b0; wmask = 4'd0; reg_sel = 2'd0;
        data_in = 32'd0; rxd = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        checks++; if (data_out !== 32'd0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b exp=1", txd); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        bus_read(2'd1, d);
        checks++; if (d !== 32'h45) begin failures++; $display("FAIL reset_status got=%h exp=00000045", d); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'd104) begin failures++; $display("FAIL reset_div got=%0d exp=104", d); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", d); end
    endtask

    task automatic test_tx();
        logic [31:0] d;
        logic [7:0]  b, exp;
        int unsigned start, first, prev;
        int n;
        tx_q.push_back(8'h55); bus_write(2'd0, 4'b0001, 32'h55);
        tx_q.push_back(8'hA3); bus_write(2'd0, 4'b0001, 32'hA3);
        checks++; if (txd !== 1'b0) begin failures++; $display("FAIL tx_start_latency txd=%b exp=0", txd); end
        start = cyc; first = cyc;
        bus_read(2'd1, d);
        checks++; if (d !== 32'h0001_0004) begin failures++; $display("FAIL tx_status_busy got=%h exp=00010004", d); end
        for (int f = 0; f < 2; f++) begin
            if (f == 1) begin
                prev = start; n = 0;
                while (txd !== 1'b0 && n < 3000) begin @(posedge clk12MHz); #1; n++; end
                start = cyc;
                checks++; if (start - prev != 1041) begin failures++; $display("FAIL tx_frame_spacing got=%0d exp=1041", start - prev); end
            end
            b = 8'd0;
            while (cyc < start + 52) begin @(posedge clk12MHz); #1; end
            checks++; if (txd !== 1'b0) begin failures++; $display("FAIL tx_start_bit frame=%0d got=%b exp=0", f, txd); end
            for (int k = 0; k < 8; k++) begin
                while (cyc < start + 52 + 104 * (k + 1)) begin @(posedge clk12MHz); #1; end
                b[k] = txd;
            end
            while (cyc < start + 52 + 936) begin @(posedge clk12MHz); #1; end
            checks++; if (txd !== 1'b1) begin failures++; $display("FAIL tx_stop_bit frame=%0d got=%b exp=1", f, txd); end
            exp = (tx_q.size() > 0) ? tx_q.pop_front() : 8'hxx;
            checks++; if (b !== exp) begin failures++; $display("FAIL tx_byte frame=%0d got=%h exp=%h", f, b, exp); end
        end
        n = 0; d = 32'd0;
        while (d[6] !== 1'b1 && n < 300) begin bus_read(2'd1, d); n++; end
        checks++; if (d !== 32'h45) begin failures++; $display("FAIL tx_idle_status got=%h exp=00000045", d); end
        checks++; if (cyc - first != 2082) begin failures++; $display("FAIL tx_idle_time got=%0d exp=2082", cyc - first); end
    endtask

    task automatic test_tx_overflow();
        logic [31:0] d;
        int n;
        bus_write(2'd2, 4'b0011, 32'h1);
        bus_read(2'd2, d);
        checks++; if (d !== 32'd4) begin failures++; $display("FAIL div_clamp got=%0d exp=4", d); end
        for (int i = 0; i < 18; i++) bus_write(2'd0, 4'b0001, 32'h80 + i);
        bus_read(2'd1, d);
        checks++; if (d !== 32'h0010_0016) begin failures++; $display("FAIL tx_ovf_status got=%h exp=00100016", d); end
        bus_write(2'd1, 4'b0001, 32'h10);
        bus_read(2'd1, d);
        checks++; if (d !== 32'h0010_0006) begin failures++; $display("FAIL tx_ovf_w1c got=%h exp=00100006", d); end
        n = 0; d = 32'd0;
        while (d[6] !== 1'b1 && n < 2000) begin bus_read(2'd1, d); n++; end
        checks++; if (d !== 32'h45) begin failures++; $display("FAIL tx_drain got=%h exp=00000045", d); end
        bus_write(2'd2, 4'b0011, 32'hABCD_1234);
        bus_write(2'd2, 4'b0001, 32'hFFFF_FF68);
        bus_read(2'd2, d);
        checks++; if (d !== 32'h1268) begin failures++; $display("FAIL div_byte_lanes got=%h exp=00001268", d); end
        bus_write(2'd2, 4'b0011, 32'd104);
    endtask

    task automatic test_rx();
        logic [31:0] d, exp;
        rx_q.push_back(32'h131); send_frame(8'h31, 1'b1);
        rx_q.push_back(32'h132); send_frame(8'h32, 1'b1);
        bus_read(2'd1, d);
        checks++; if (d[15:8] !== 8'd2) begin failures++; $display("FAIL rx_count got=%0d exp=2", d[15:8]); end
        for (int i = 0; i < 2; i++) begin
            bus_read(2'd0, d);
            exp = (rx_q.size() > 0) ? rx_q.pop_front() : 32'hxxxx_xxxx;
            checks++; if (d !== exp) begin failures++; $display("FAIL rx_data idx=%0d got=%h exp=%h", i, d, exp); end
        end
        valid = 1'b0; read = 1'b1; reg_sel = 2'd3;
        wait_cycles(1);
        read = 1'b0;
        checks++; if (data_out !== 32'h132) begin failures++; $display("FAIL rd_hold got=%h exp=00000132", data_out); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL rx_empty_read got=%h exp=0", d); end
        bus_read(2'd1, d);
        checks++; if (d !== 32'h45) begin failures++; $display("FAIL rx_no_pop_status got=%h exp=00000045", d); end
    endtask

    task automatic test_rx_errors();
        logic [31:0] d, exp;
        for (int i = 0; i < 17; i++) begin
            if (i < 16) rx_q.push_back({23'd0, 1'b1, 8'h40 + 8'(i)});
            send_frame(8'h40 + 8'(i), 1'b1);
        end
        bus_read(2'd1, d);
        checks++; if (d !== 32'h0000_1069) begin failures++; $display("FAIL rx_ovf_status got=%h exp=00001069", d); end
        for (int i = 0; i < 16; i++) begin
            bus_read(2'd0, d);
            exp = (rx_q.size() > 0) ? rx_q.pop_front() : 32'hxxxx_xxxx;
            checks++; if (d !== exp) begin failures++; $display("FAIL rx_retained idx=%0d got=%h exp=%h", i, d, exp); end
        end
        bus_read(2'd0, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL rx_drained got=%h exp=0", d); end
        send_frame(8'h77, 1'b0);
        wait_cycles(20);
        bus_read(2'd1, d);
        checks++; if (d !== 32'h0000_00E5) begin failures++; $display("FAIL frame_err_status got=%h exp=000000e5", d); end
        bus_write(2'd1, 4'b0001, 32'hA0);
        bus_read(2'd1, d);
        checks++; if (d !== 32'h45) begin failures++; $display("FAIL rx_w1c got=%h exp=00000045", d); end
        rxd = 1'b0;
        wait_cycles(20);
        rxd = 1'b1;
        wait_cycles(1200);
        bus_read(2'd1, d);
        checks++; if (d !== 32'h45) begin failures++; $display("FAIL rx_glitch got=%h exp=00000045", d); end
    endtask

    task automatic test_irq();
        logic [31:0] d, exp;
        bus_write(2'd3, 4'b0001, 32'd1);
        wait_cycles(2);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_idle got=%b exp=0", irq); end
        rx_q.push_back(32'h15A);
        send_frame(8'h5A, 1'b1);
        wait_cycles(2);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rx got=%b exp=1", irq); end
        bus_read(2'd0, d);
        exp = (rx_q.size() > 0) ? rx_q.pop_front() : 32'hxxxx_xxxx;
        checks++; if (d !== exp) begin failures++; $display("FAIL irq_rx_data got=%h exp=%h", d, exp); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_hold got=%b exp=1", irq); end
        wait_cycles(1);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_drop got=%b exp=0", irq); end
        bus_write(2'd3, 4'b0001, 32'd2);
        wait_cycles(1);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_tx got=%b exp=1", irq); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'd2) begin failures++; $display("FAIL ctrl_read got=%h exp=2", d); end
        bus_write(2'd3, 4'b0001, 32'd0);
    endtask

    task automatic test_midframe_reset();
        logic [31:0] d;
        for (int i = 0; i < 3; i++) bus_write(2'd0, 4'b0001, 32'h00);
        wait_cycles(300);
        checks++; if (txd !== 1'b0) begin failures++; $display("FAIL midframe_txd got=%b exp=0", txd); end
        bus_write(2'd2, 4'b0011, 32'd50);
        rst = 1'b1;
        wait_cycles(1);
        checks++; if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd_next got=%b exp=1", txd); end
        rst = 1'b0;
        bus_read(2'd1, d);
        checks++; if (d !== 32'h45) begin failures++; $display("FAIL reset_fifos got=%h exp=00000045", d); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'd104) begin failures++; $display("FAIL reset_div_again got=%0d exp=104", d); end
    endtask

    initial begin
        test_reset();
        test_tx();
        test_tx_overflow();
        test_rx();
        test_rx_errors();
        test_irq();
        test_midframe_reset();
        checks++;
        if (tx_q.size() != 0 || rx_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover tx=%0d rx=%0d exp=0", tx_q.size(), rx_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
